leb128_i64_collector: RTL and testbench

LEB128_I64_COLLECTOR -- requirements
Module: leb128_i64_collector

---
 rtl/leb128_i64_collector.sv | 132 +++++++++++++
 tb/tb_leb128_i64_collector.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leb128_i64_collector.sv
// Collects one LEB128-encoded integer (up to MAX_BYTES bytes) into a byte window
// for a parallel decoder; overlong encodings are flagged and their tail drained.
module leb128_i64_collector #(
    parameter int MAX_BYTES = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [8*MAX_BYTES-1:0] m_data,
    output logic [3:0]             m_len,
    output logic                   m_err,
    output logic                   m_valid,
    input  logic                   m_ready
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(MAX_BYTES - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] len;
    logic       err;
    logic [7:0] slots [MAX_BYTES];

    logic       s_fire;
    logic       m_fire;
    logic       close;
    logic       wr_en;
    logic       restart;
    logic [3:0] wr_idx;

    // A byte accepted in HOLD is slot 0 of the next window.
    always_comb begin
        s_fire  = s_valid && s_ready;
        m_fire  = m_valid && m_ready;
        wr_idx  = (state == HOLD) ? 4'd0 : cnt;
        close   = !s_data[7] || (wr_idx == LAST);
        wr_en   = s_fire && (state != DRAIN);
        restart = ((state == HOLD) && m_fire)
               || ((state == DRAIN) && s_fire && !s_data[7]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            COLLECT: begin
                if (s_fire && close) state_nx = HOLD;
            end
            HOLD: begin
                if (m_fire) begin
                    if (err)                 state_nx = DRAIN;
                    else if (s_fire && close) state_nx = HOLD;
                    else                     state_nx = COLLECT;
                end
            end
            DRAIN: begin
                if (s_fire && !s_data[7]) state_nx = COLLECT;
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        unique case (state)
            COLLECT: s_ready = rst_n;
            HOLD: begin
                m_valid = 1'b1;
                s_ready = rst_n && m_ready && !err;
            end
            DRAIN:   s_ready = rst_n;
            default: s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
            len <= 4'd0;
            err <= 1'b0;
            for (int k = 0; k < MAX_BYTES; k++) begin
                slots[k] <= 8'h00;
            end
        end else begin
            if (restart) begin
                cnt <= 4'd0;
                for (int k = 0; k < MAX_BYTES; k++) begin
                    slots[k] <= 8'h00;
                end
            end
            if (wr_en) begin
                slots[wr_idx] <= s_data;
                if (close) begin
                    cnt <= 4'd0;
                    len <= wr_idx + 4'd1;
                    err <= s_data[7];
                end else begin
                    cnt <= wr_idx + 4'd1;
                end
            end
        end
    end

    always_comb begin
        m_len  = len;
        m_err  = err;
        m_data = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (m_valid && (4'(k) < len)) begin
                m_data[8*k +: 8] = slots[k];
            end
        end
    end

endmodule

// File: tb/tb_leb128_i64_collector.sv
// Scoreboard bench for leb128_i64_collector: a byte-stream reference model
// predicts windows, a monitor pops and compares on every output handshake.
module tb_leb128_i64_collector;

    localparam int MB = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [8*MB-1:0] m_data;
    logic [3:0]    m_len;
    logic          m_err;
    logic          m_valid;
    logic          m_ready = 1'b0;

    leb128_i64_collector #(.MAX_BYTES(MB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_data (m_data),
        .m_len  (m_len),
        .m_err  (m_err),
        .m_valid(m_valid),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8*MB-1:0] data;
        logic [3:0]      len;
        logic            err;
    } win_t;

    win_t       exp_q[$];
    logic [7:0] part[$];
    bit         draining = 0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rdy_mode = 1;
    int         gap_max = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: split the accepted byte stream into windows by the LEB128 rules.
    function automatic bit model_push(input logic [7:0] b);
        win_t w;
        if (draining) begin
            if (!b[7]) draining = 0;
            return 0;
        end
        part.push_back(b);
        if (!b[7] || part.size() == MB) begin
            w.data = '0;
            foreach (part[i]) w.data[8*i +: 8] = part[i];
            w.len = 4'(part.size());
            w.err = b[7];
            exp_q.push_back(w);
            draining = b[7];
            part.delete();
            return 1;
        end
        return 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = ($urandom_range(0, 3) != 0);
                1:       m_ready = 1'b1;
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every output handshake and stall stability.
    initial begin
        win_t w;
        bit held;
        logic [8*MB-1:0] h_data;
        logic [3:0] h_len;
        logic h_err;
        held = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
            end else begin
                if (m_valid && !m_ready) begin
                    check("stall_s_ready", s_ready, 0);
                    if (held) begin
                        check("stall_data", m_data, h_data);
                        check("stall_len", m_len, h_len);
                        check("stall_err", m_err, h_err);
                    end
                    held = 1;
                    h_data = m_data;
                    h_len = m_len;
                    h_err = m_err;
                end else begin
                    held = 0;
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_window: got len %0d expected none",
                                 m_len);
                    end else begin
                        w = exp_q.pop_front();
                        check("win_data", m_data, w.data);
                        check("win_len", m_len, w.len);
                        check("win_err", m_err, w.err);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int waitc;
        bit closed;
        bit ok;
        if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
        s_data = b;
        s_valid = 1'b1;
        waitc = 0;
        ok = 0;
        while (!ok && waitc < 500) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
            end else begin
                waitc++;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            check("send_timeout", 0, 1);
            s_valid = 1'b0;
            return;
        end
        closed = model_push(b);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        if (closed) check("latency_m_valid", m_valid, 1);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_len", m_len, 0);
        check("rst_m_err", m_err, 0);
        part.delete();
        draining = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_ready", s_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        logic [7:0] b;
        logic [8*MB-1:0] ff_win;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // FF x9, 01 -> len 10, err 0, one byte per cycle
        rdy_mode = 1;
        t0 = cyc;
        repeat (9) send(8'hFF);
        send(8'h01);
        check("thru_10", cyc - t0, 10);
        ff_win = '1;
        ff_win[8*MB-1 -: 8] = 8'h01;
        check("ff9_data", m_data, ff_win);
        check("ff9_len", m_len, 10);
        wait_empty();

        // back-to-back single-byte windows
        t0 = cyc;
        send(8'h7F);
        send(8'h02);
        check("thru_2", cyc - t0, 2);
        wait_empty();

        // stalled output
        rdy_mode = 2;
        send(8'hE5);
        send(8'h8E);
        send(8'h26);
        fork
            send(8'h00);
            begin
                repeat (5) @(posedge clk);
                #1;
                check("hold_valid", m_valid, 1);
                check("hold_len", m_len, 3);
                rdy_mode = 1;
            end
        join
        wait_empty();

        // overlong then drain
        repeat (10) send(8'h80);
        send(8'h80);
        send(8'h80);
        send(8'h05);
        send(8'h03);
        wait_empty();

        // reset mid-window
        send(8'hE5);
        send(8'h8E);
        do_reset();
        send(8'h01);
        wait_empty();

        // random streams with stalls on both sides
        rdy_mode = 0;
        gap_max = 2;
        for (int v = 0; v < 300; v++) begin
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 13)
                                            : $urandom_range(1, MB);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                b[7] = (i < n - 1);
                send(b);
            end
        end
        rdy_mode = 1;
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
